// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
//
// Shares the 8088 local bus between the CPU and four DMA channels. Bus
// ownership is negotiated with the CPU through hold/hlda. Once the CPU lets go,
// the bus is granted to one channel at a time with fixed priority (channel 0
// highest). An internal timer raises periodic DRAM refresh requests on
// channel 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   dreq[3:0]    level-sensitive DMA requests, one per channel
//   mask_we      write strobe for the channel mask register
//   mask_wdata   new mask value (1 = channel masked, refresh included)
//   hlda         hold acknowledge from the processor
//   xfer_done    one-cycle pulse per completed byte transfer
//   hold         bus request to the processor
//   aen          DMA owns the bus, CPU address drivers must float
//   dack[3:0]    one-hot grant to the active channel
//   busy         arbiter is not idle
//   refresh_miss one-cycle pulse when a refresh request is overrun
// -----------------------------------------------------------------------------
module dma_bus_arbiter #(
    parameter int REFRESH_PERIOD = 72,
    parameter int REFRESH_EN     = 1,
    parameter int MAX_BURST      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dreq,
    input  logic       mask_we,
    input  logic [3:0] mask_wdata,
    input  logic       hlda,
    input  logic       xfer_done,
    output logic       hold,
    output logic       aen,
    output logic [3:0] dack,
    output logic       busy,
    output logic       refresh_miss
);

    localparam int                 CNT_W       = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [4:0]         BURST_LIMIT = 5'(MAX_BURST);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] burst_q, burst_d;
    logic [3:0] mask_q, mask_d;
    logic       hold_q, hold_d;
    logic       aen_q, aen_d;
    logic [3:0] dack_q, dack_d;

    logic       refresh_pending;
    logic       refresh_clear;
    logic [3:0] eff;
    logic [1:0] first_ch;
    logic [4:0] burst_inc;

    // The refresh transfer is the one that completes while channel 0 holds
    // the grant; that is what retires the pending refresh request.
    assign refresh_clear = xfer_done & dack_q[0];

    // -------------------------------------------------------------------------
    // Refresh timer
    // -------------------------------------------------------------------------
    generate
        if (REFRESH_EN != 0) begin : g_refresh
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             pend_q, pend_d;
            logic             miss_q, miss_d;
            logic             term;

            always_comb begin
                term   = (cnt_q == CNT_LAST);
                cnt_d  = term ? '0 : cnt_q + CNT_W'(1);
                miss_d = term & pend_q;
                pend_d = pend_q;
                if (refresh_clear) begin
                    pend_d = 1'b0;
                end
                // A new request arriving together with the clear wins.
                if (term) begin
                    pend_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q  <= '0;
                    pend_q <= 1'b0;
                    miss_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    pend_q <= pend_d;
                    miss_q <= miss_d;
                end
            end

            assign refresh_pending = pend_q;
            assign refresh_miss    = miss_q;
        end else begin : g_no_refresh
            assign refresh_pending = 1'b0;
            assign refresh_miss    = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Effective requests: refresh rides on channel 0 and obeys its mask bit.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_eff
            if (gi == 0) begin : g_ch0
                assign eff[gi] = (dreq[gi] | refresh_pending) & ~mask_q[gi];
            end else begin : g_chn
                assign eff[gi] = dreq[gi] & ~mask_q[gi];
            end
        end
    endgenerate

    // Lowest-index active request wins.
    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eff[i]) begin
                first_ch = 2'(i);
            end
        end
    end

    // Mask changes only influence the next arbitration or the next
    // end-of-transfer decision; an existing grant is left in place.
    always_comb begin
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    // -------------------------------------------------------------------------
    // Bus ownership FSM. Outputs are registered and move together with the
    // state, so aen and dack always switch on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        burst_d   = burst_q;
        hold_d    = hold_q;
        aen_d     = aen_q;
        dack_d    = dack_q;
        burst_inc = {1'b0, burst_q} + 5'd1;

        case (state_q)
            ST_IDLE: begin
                if (|eff) begin
                    state_d = ST_REQ;
                    hold_d  = 1'b1;
                end
            end

            ST_REQ: begin
                // No timeout: hold stays up until the CPU answers.
                if (hlda) begin
                    if (|eff) begin
                        state_d = ST_GRANT;
                        ch_d    = first_ch;
                        burst_d = 4'd0;
                        aen_d   = 1'b1;
                        dack_d  = 4'b0001 << first_ch;
                    end else begin
                        // Request vanished while waiting: hand the bus back.
                        state_d = ST_RELEASE;
                        hold_d  = 1'b0;
                    end
                end
            end

            ST_GRANT: begin
                // Higher-priority requests are not allowed to preempt; the
                // grant only ends on a transfer boundary.
                if (xfer_done) begin
                    burst_d = burst_inc[3:0];
                    if ((burst_inc == BURST_LIMIT) || !eff[ch_q]) begin
                        state_d = ST_RELEASE;
                        hold_d  = 1'b0;
                        aen_d   = 1'b0;
                        dack_d  = 4'b0000;
                    end
                end
            end

            ST_RELEASE: begin
                // Returning through IDLE guarantees the CPU at least one
                // cycle of bus ownership between grants.
                if (!hlda) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
                aen_d   = 1'b0;
                dack_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            burst_q <= 4'd0;
            mask_q  <= 4'b0000;
            hold_q  <= 1'b0;
            aen_q   <= 1'b0;
            dack_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            aen_q   <= aen_d;
            dack_q  <= dack_d;
        end
    end

    assign hold = hold_q;
    assign aen  = aen_q;
    assign dack = dack_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the arbiter (bus phase, owning channel, transfer count, refresh tick) runs
// alongside the DUT and predicts every output on every clock.
// -----------------------------------------------------------------------------
module tb_dma_bus_arbiter;

    localparam int P  = 12;
    localparam int MB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dreq_r = 4'b0000;
    logic       mask_we_r = 1'b0;
    logic [3:0] mask_wdata_r = 4'b0000;
    logic       hlda_r = 1'b0;
    logic       xfer_r = 1'b0;
    logic       hold, aen, busy, refresh_miss;
    logic [3:0] dack;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Model state: phase 0 idle, 1 requesting, 2 granted, 3 releasing.
    int         m_phase, m_owner, m_count, m_tick;
    logic [3:0] m_mask;
    bit         m_pend, m_miss;

    dma_bus_arbiter #(
        .REFRESH_PERIOD(P),
        .REFRESH_EN(1),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dreq(dreq_r),
        .mask_we(mask_we_r),
        .mask_wdata(mask_wdata_r),
        .hlda(hlda_r),
        .xfer_done(xfer_r),
        .hold(hold),
        .aen(aen),
        .dack(dack),
        .busy(busy),
        .refresh_miss(refresh_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_count = 0;
        m_tick  = 0;
        m_mask  = 4'b0000;
        m_pend  = 0;
        m_miss  = 0;
    endtask

    function automatic logic exp_hold();
        return (m_phase == 1) || (m_phase == 2);
    endfunction

    function automatic logic [7:0] exp_outs();
        logic [3:0] d;
        d = (m_phase == 2) ? 4'(1 << m_owner) : 4'b0000;
        return {exp_hold(), m_phase == 2, d, m_phase != 0, m_miss};
    endfunction

    // One clock edge of the arbiter's rules, using the inputs present at it.
    task automatic model_step();
        logic [3:0] eff;
        bit         term, clr;
        int         lowest;
        eff    = (dreq_r | {3'b000, m_pend}) & ~m_mask;
        term   = (m_tick == P - 1);
        clr    = xfer_r && (m_phase == 2) && (m_owner == 0);
        m_miss = term && m_pend;
        m_tick = term ? 0 : m_tick + 1;
        lowest = -1;
        for (int i = 0; i < 4; i++) begin
            if (eff[i] && lowest < 0) lowest = i;
        end
        case (m_phase)
            0: if (eff != 0) m_phase = 1;
            1: if (hlda_r) begin
                if (lowest >= 0) begin
                    m_phase = 2;
                    m_owner = lowest;
                    m_count = 0;
                end else begin
                    m_phase = 3;
                end
            end
            2: if (xfer_r) begin
                m_count++;
                if (m_count == MB || !eff[m_owner]) m_phase = 3;
            end
            default: if (!hlda_r) m_phase = 0;
        endcase
        if (term)     m_pend = 1;
        else if (clr) m_pend = 0;
        if (mask_we_r) m_mask = mask_wdata_r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("outs", {hold, aen, dack, busy, refresh_miss}, exp_outs());
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we_r = 1'b1;
        mask_wdata_r = v;
        tick();
        mask_we_r = 1'b0;
    endtask

    task automatic random_cycle(input bit allow_mask);
        if ($urandom_range(0, 7) == 0) dreq_r = 4'($urandom);
        xfer_r = ($urandom_range(0, 2) == 0);
        mask_we_r = allow_mask && ($urandom_range(0, 39) == 0);
        mask_wdata_r = 4'($urandom);
        if ($urandom_range(0, 1) == 1) hlda_r = exp_hold();
        tick();
    endtask

    initial begin
        int n_miss;
        model_reset();

        // Reset: all outputs low.
        #2 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset", {hold, aen, dack, busy, refresh_miss}, 8'h00);
        rst = 1'b1;

        // Refresh with no dreq: hold one clock after the first terminal count.
        for (int i = 0; i < P; i++) tick();
        check("refresh_early", hold, 1'b0);
        tick();
        check("refresh_hold", hold, 1'b1);

        // Withheld hlda: the pending refresh is overrun at every terminal count.
        n_miss = 0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            if (refresh_miss) n_miss++;
        end
        check("miss_count", n_miss, 2);
        hlda_r = 1'b1;
        tick();
        check("refresh_dack", dack, 4'b0001);
        xfer_r = 1'b1;
        tick();
        tick();
        check("refresh_done", {hold, aen, dack}, 6'b0);
        xfer_r = 1'b0;
        hlda_r = 1'b0;
        tick();
        check("refresh_idle", busy, 1'b0);

        // Channel 2 single transfer, channel 0 (refresh) masked off.
        write_mask(4'b0001);
        dreq_r = 4'b0100;
        tick();
        check("ch2_hold", hold, 1'b1);
        tick();
        hlda_r = 1'b1;
        tick();
        check("ch2_dack", {aen, dack}, 5'b10100);
        xfer_r = 1'b1;
        dreq_r = 4'b0000;
        tick();
        check("ch2_release", {hold, aen, dack}, 6'b0);
        xfer_r = 1'b0;
        tick();
        hlda_r = 1'b0;
        tick();
        check("ch2_idle", busy, 1'b0);

        // Priority: channels 1 and 3 together.
        dreq_r = 4'b1010;
        tick();
        hlda_r = 1'b1;
        tick();
        check("prio_first", dack, 4'b0010);
        xfer_r = 1'b1;
        dreq_r = 4'b1000;
        tick();
        xfer_r = 1'b0;
        hlda_r = 1'b0;
        tick();
        tick();
        check("prio_rereq", {hold, dack}, 5'b10000);
        hlda_r = 1'b1;
        tick();
        check("prio_second", dack, 4'b1000);
        xfer_r = 1'b1;
        dreq_r = 4'b0000;
        tick();
        xfer_r = 1'b0;
        hlda_r = 1'b0;
        tick();

        // Full burst on channel 1.
        dreq_r = 4'b0010;
        tick();
        hlda_r = 1'b1;
        tick();
        for (int k = 1; k <= MB; k++) begin
            xfer_r = 1'b1;
            tick();
            xfer_r = 1'b0;
            if (k < MB) begin
                check("burst_hold", aen, 1'b1);
                tick();
            end else begin
                check("burst_end", aen, 1'b0);
            end
        end
        dreq_r = 4'b0000;
        hlda_r = 1'b0;
        tick();

        // Burst cut short by dropping the request.
        dreq_r = 4'b0010;
        tick();
        hlda_r = 1'b1;
        tick();
        xfer_r = 1'b1;
        tick();
        xfer_r = 1'b0;
        dreq_r = 4'b0000;
        tick();
        xfer_r = 1'b1;
        tick();
        check("burst_drop", aen, 1'b0);
        xfer_r = 1'b0;
        hlda_r = 1'b0;
        tick();

        // Masked channel never raises hold.
        write_mask(4'b0101);
        dreq_r = 4'b0100;
        repeat (4) tick();
        check("mask_block", hold, 1'b0);
        dreq_r = 4'b0000;

        // Mask written during a grant does not revoke it.
        write_mask(4'b0001);
        dreq_r = 4'b0100;
        tick();
        hlda_r = 1'b1;
        tick();
        write_mask(4'b0101);
        check("mask_keep", dack, 4'b0100);
        xfer_r = 1'b1;
        tick();
        check("mask_finish", aen, 1'b0);
        xfer_r = 1'b0;
        hlda_r = 1'b0;
        dreq_r = 4'b0000;
        tick();

        // Randomized traffic.
        write_mask(4'b0000);
        for (int i = 0; i < 3000; i++) random_cycle(1'b1);

        // Asynchronous reset in the middle of a grant.
        write_mask(4'b0100);
        for (int i = 0; i < 500 && m_phase != 2; i++) random_cycle(1'b0);
        #3 rst = 1'b0;
        #1;
        check("async_rst", {hold, aen, dack}, 6'b0);
        model_reset();
        dreq_r = 4'b0000;
        hlda_r = 1'b0;
        xfer_r = 1'b0;
        mask_we_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dreq_r = 4'b0100;
        tick();
        check("rst_mask_clr", hold, 1'b1);
        for (int i = 0; i < 400; i++) random_cycle(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
Shares the 8088 local address/data bus between the CPU and four DMA channels. It negotiates bus ownership with the CPU through the hold/hlda handshake and grants the bus to one channel at a time using fixed priority, with channel 0 highest. It also generates periodic DRAM refresh requests on channel 0. It sits between the processor wrapper and the DMA transfer engine, and it owns the hold input of the processor.

Parameters:
REFRESH_PERIOD, 72, clocks between refresh requests; minimum 2.
REFRESH_EN, 1, 1 enables the internal refresh timer; 0 ties it off.
MAX_BURST, 1, maximum transfers per grant; range 1..15.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-low.
dreq  in  4  DMA request per channel; level-sensitive, active-high.
mask_we  in  1  write strobe for the mask register.
mask_wdata  in  4  new mask value; a 1 masks that channel.
hlda  in  1  hold acknowledge from the processor.
xfer_done  in  1  one-cycle pulse from the transfer engine when one byte transfer completes.
hold  out  1  bus request to the processor.
aen  out  1  DMA owns the bus; the CPU address drivers must float.
dack  out  4  one-hot grant to the active channel.
busy  out  1  arbiter is not in IDLE.
refresh_miss  out  1  one-cycle pulse when a refresh request is overrun.

Behaviour:
Reset:
- All outputs are 0.
- mask = 4'b0000.
- refresh_pending = 0.
- Refresh counter = 0; burst counter = 0.
- State = IDLE.
- Reset asserted mid-grant drops hold, aen and dack immediately (asynchronous).

Effective request:
- eff[i] = (dreq[i] | (i==0 & refresh_pending)) & ~mask[i].
- The mask applies to refresh as well.
- A mask write takes effect the cycle after mask_we. A mask write does not revoke a grant already given.

Refresh timer:
- Free-running counter 0..REFRESH_PERIOD-1.
- At terminal count: set refresh_pending; wrap to 0.
- If refresh_pending is already 1 at terminal count: pulse refresh_miss; pending stays 1.
- refresh_pending clears on xfer_done while dack[0] is set.
- If terminal count and that clear happen in the same cycle, pending stays set (the new request wins).

FSM (registered outputs; decisions on the clk edge):
- IDLE:
  - If |eff, go to REQ and assert hold the next cycle.
- REQ (hold=1):
  - Wait for hlda=1.
  - On hlda, if |eff: latch ch = lowest-index set eff bit; go to GRANT; aen=1, dack[ch]=1, burst=0.
  - On hlda, if eff=0 (request withdrawn): go to RELEASE.
  - There is no timeout; hold stays up until hlda.
- GRANT (hold=1, aen=1, dack one-hot):
  - On xfer_done: burst++.
  - Leave for RELEASE if burst+1==MAX_BURST, or if eff[ch] is 0 in the xfer_done cycle.
  - Otherwise stay in GRANT on the same channel. A higher-priority request does not preempt mid-burst.
  - xfer_done in any other state is ignored.
- RELEASE (hold=0, aen=0, dack=0):
  - Wait for hlda=0, then go to IDLE.
  - Re-arbitration happens no earlier than the cycle after IDLE.
  - The CPU always gets at least one cycle of bus between grants.

Output timing:
- busy = (state != IDLE).
- dack and aen change in the same cycle.
- dack is never non-zero while aen=0.

Timing:
- dreq rise to hold: 1 clk.
- hlda rise to aen/dack: 1 clk.
- Final xfer_done to hold/aen/dack low: 1 clk.

Test Plan:
- Channel 2 request: dreq=4'b0100, hlda returned 2 clk after hold → hold=1 at clk+1; aen=1, dack=4'b0100 one clk after hlda. One xfer_done → hold, aen, dack all 0 next clk; IDLE after hlda drops.
- Priority: dreq=4'b1010 simultaneously → dack=4'b0010 first; after release and return to IDLE, dack=4'b1000 on the second grant.
- Refresh with REFRESH_PERIOD=8 and no dreq: hold rises at clk 9 after reset; dack=4'b0001; xfer_done clears refresh_pending. Withholding hlda for 20 clk → refresh_miss pulses at each subsequent terminal count.
- Burst with MAX_BURST=3 and dreq[1] held high → three xfer_done pulses within one grant, then release. Dropping dreq[1] before the 2nd xfer_done → release after 2 transfers.
- Mask: write mask=4'b0100, then dreq=4'b0100 → hold stays 0. Mask written while channel 2 is granted → grant completes normally.
- Asynchronous reset low mid-GRANT → hold, aen, dack = 0 with no clk edge; after reset release, mask=0 and refresh counter restarts.
